vector_store_unit: RTL and testbench

- Downstream of the vector ALU; executes VST (opcode 4'b0101).
- Captures one 256-bit vector, 16 lanes of 16-bit half-float, plus a base address.
- Serialises the vector into 16 sequential 16-bit memory writes using a valid/ack handshake.
- Reports busy and a one-cycle done pulse to the issue/control logic.

---
 rtl/vector_store_unit_if.sv | 24 ++
 rtl/vector_store_unit.sv | 149 ++++++++++++++
 tb/tb_vector_store_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_store_unit_if.sv
// Memory write port of the vector store unit: valid/ack handshake carrying one lane per beat.
interface vector_store_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LANE_WIDTH = 16
) ();
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LANE_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/vector_store_unit.sv
// VST execution unit: captures a vector and base address, then writes it out one lane per beat.
// Define VST_STRIDE_EN to add a per-store address stride; otherwise lanes go to consecutive words.
module vector_store_unit #(
  parameter int LANES      = 16,
  parameter int LANE_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LANES*LANE_WIDTH-1:0] vec_data,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
`ifdef VST_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]       stride,
`endif
  output logic                        busy,
  output logic                        done,
  vector_store_unit_if.master         mem
);

  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  logic [1:0]                            state_q, state_d;
  logic [LANE_BITS-1:0]                  lane_q, lane_d;
  logic [LANE_BITS-1:0]                  lane_inc;
  logic [LANES-1:0][LANE_WIDTH-1:0]      vec_q, vec_d;
  logic [ADDR_WIDTH-1:0]                 addr_q, addr_d;
  logic [LANE_WIDTH-1:0]                 wdata_q, wdata_d;
  logic                                  we_q, we_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic [ADDR_WIDTH-1:0]                 step;

`ifdef VST_STRIDE_EN
  logic [ADDR_WIDTH-1:0]                 stride_q, stride_d;

  always_comb begin
    stride_d = stride_q;
    if (state_q == IDLE && start) begin
      stride_d = stride;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(1);
`endif

  assign lane_inc = lane_q + 1'b1;

  // The address advances by one step per accepted beat, so lane i lands at base + i*step mod 2^ADDR_WIDTH.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          lane_d  = '0;
          vec_d   = vec_data;
          addr_d  = base_addr;
          wdata_d = vec_data[LANE_WIDTH-1:0];
          we_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      WRITE: begin
        if (mem.mem_ack) begin
          if (lane_q == LAST_LANE) begin
            state_d = DONE;
            lane_d  = '0;
            addr_d  = '0;
            wdata_d = '0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            lane_d  = lane_inc;
            addr_d  = addr_q + step;
            wdata_d = vec_q[lane_inc];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        lane_d  = '0;
        addr_d  = '0;
        wdata_d = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      vec_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// Directed bench for vector_store_unit: streaming, stall, wrap, ignored start and reset mid-store.
// Builds with or without VST_STRIDE_EN; the stride-specific expectations follow the macro.
module tb_vector_store_unit;

   localparam int LANES      = 16;
   localparam int LANE_WIDTH = 16;
   localparam int ADDR_WIDTH = 16;

`ifdef VST_STRIDE_EN
   localparam logic [15:0] MID_STEP = 16'd4;
`else
   localparam logic [15:0] MID_STEP = 16'd1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] vecData;
   logic [15:0]  baseAddr;
`ifdef VST_STRIDE_EN
   logic [15:0]  strideIn;
`endif
   logic         busy;
   logic         done;

   int errorCount = 0;
   int checkCount = 0;

   vector_store_unit_if #(.ADDR_WIDTH(ADDR_WIDTH), .LANE_WIDTH(LANE_WIDTH)) memIf ();

   vector_store_unit #(
      .LANES     (LANES),
      .LANE_WIDTH(LANE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .vec_data (vecData),
      .base_addr(baseAddr),
`ifdef VST_STRIDE_EN
      .stride   (strideIn),
`endif
      .busy     (busy),
      .done     (done),
      .mem      (memIf)
   );

   // Free-running 10 ns clock; outputs are sampled on the falling edge
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Lane i of the returned vector holds first+i
   function automatic logic [255:0] makeVec(input logic [15:0] first);
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) begin
         v[16*i +: 16] = first + 16'(i);
      end
      return v;
   endfunction

   // Presents a one-cycle start so that it is sampled at the next rising edge (edge 0)
   task automatic applyStimulus(input logic [255:0] vec, input logic [15:0] base);
      @(negedge clk);
      vecData  = vec;
      baseAddr = base;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Runs one complete store and checks every beat against base + lane*step and the lane data.
   // Optionally stalls one lane, and pulses a junk start at a WRITE cycle and/or the DONE cycle.
   task automatic runAndCheck(input string name, input logic [255:0] vec, input logic [15:0] base,
                              input logic [15:0] step, input int stallLane, input int stallCycles,
                              input int junkCycle, input bit junkAtDone);
      int          expLane;
      int          stalled;
      int          latency;
      logic [15:0] expAddr;
      logic [15:0] expData;
      expLane = 0;
      stalled = 0;
      latency = 0;
`ifdef VST_STRIDE_EN
      strideIn = step;
`endif
      memIf.mem_ack = 1'b1;
      applyStimulus(vec, base);
      for (int c = 1; c <= 60 && latency == 0; c++) begin
         @(negedge clk);
         start = (c == junkCycle);
         if (start) begin
            vecData  = ~vec;
            baseAddr = base ^ 16'h5555;
         end
         if (expLane < LANES) begin
            expAddr = base + 16'(expLane) * step;
            expData = vec[16*expLane +: 16];
            checkOutput($sformatf("%s busy/done/we c%0d", name, c), {busy, done, memIf.mem_we}, 3'b101);
            checkOutput($sformatf("%s addr c%0d", name, c), memIf.mem_addr, expAddr);
            checkOutput($sformatf("%s data c%0d", name, c), memIf.mem_wdata, expData);
            if (expLane == stallLane && stalled < stallCycles) begin
               memIf.mem_ack = 1'b0;
               stalled++;
            end else begin
               memIf.mem_ack = 1'b1;
               expLane++;
            end
         end else begin
            latency = c;
            checkOutput($sformatf("%s done cycle", name), {busy, done, memIf.mem_we}, 3'b110);
            if (junkAtDone) begin
               start    = 1'b1;
               vecData  = ~vec;
               baseAddr = base ^ 16'h5555;
            end
         end
      end
      checkOutput($sformatf("%s done latency", name), 64'(latency), 64'(17 + stallCycles));
      @(negedge clk);
      start         = 1'b0;
      memIf.mem_ack = 1'b1;
      checkOutput($sformatf("%s idle after done", name), {busy, done, memIf.mem_we}, 3'b000);
      @(negedge clk);
      checkOutput($sformatf("%s no second store", name), {busy, done, memIf.mem_we}, 3'b000);
   endtask

   initial begin
      rst           = 1'b0;
      start         = 1'b0;
      vecData       = '0;
      baseAddr      = '0;
`ifdef VST_STRIDE_EN
      strideIn      = 16'd1;
`endif
      memIf.mem_ack = 1'b1;

      #1 rst = 1'b1;
      #1;
      checkOutput("reset busy/done/we", {busy, done, memIf.mem_we}, 3'b000);
      checkOutput("reset addr", memIf.mem_addr, 16'h0000);
      checkOutput("reset data", memIf.mem_wdata, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] streaming store");
      runAndCheck("stream", makeVec(16'h3C00), 16'h0100, 16'd1, -1, 0, -1, 1'b0);

      $display("[TB] stall on lane 5");
      runAndCheck("stall", makeVec(16'h3C00), 16'h0100, 16'd1, 5, 3, -1, 1'b0);

      $display("[TB] address wrap");
      runAndCheck("wrap", makeVec(16'hA000), 16'hFFF8, 16'd1, -1, 0, -1, 1'b0);

      $display("[TB] start ignored while busy");
      runAndCheck("ignore", makeVec(16'h1111), 16'h0300, 16'd1, -1, 0, 5, 1'b1);

`ifdef VST_STRIDE_EN
      $display("[TB] zero stride");
      runAndCheck("stride0", makeVec(16'h7700), 16'h0200, 16'd0, -1, 0, -1, 1'b0);
`endif

      $display("[TB] reset mid-store");
`ifdef VST_STRIDE_EN
      strideIn = MID_STEP;
`endif
      memIf.mem_ack = 1'b1;
      applyStimulus(makeVec(16'h5000), 16'h0400);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst busy/done/we c%0d", c), {busy, done, memIf.mem_we}, 3'b101);
         checkOutput($sformatf("midrst addr c%0d", c), memIf.mem_addr, 16'h0400 + 16'(c - 1) * MID_STEP);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst async busy/done/we", {busy, done, memIf.mem_we}, 3'b000);
      checkOutput("midrst async addr", memIf.mem_addr, 16'h0000);
      checkOutput("midrst async data", memIf.mem_wdata, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("midrst quiet c%0d", c), {busy, done, memIf.mem_we}, 3'b000);
      end
      runAndCheck("after reset", makeVec(16'h6000), 16'h0400, MID_STEP, -1, 0, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
